// File: rtl/booth_pp_accum.sv
// Multi-cycle adder for one radix-4 Booth partial-product set.
// Adds PP_PER_CYCLE sign-extended partial products per cycle and returns a 64-bit product.
module booth_pp_accum #(
    parameter int PP_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [543:0] in_pp,
    input  logic [31:0]  in_pp16,
    input  logic [15:0]  in_ec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  product,
    output logic [1:0]   dbg_state_o
);

    localparam int N_GROUPS = 16 / PP_PER_CYCLE;
    localparam int CNT_W    = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
    localparam int PP_BITS  = 34 * PP_PER_CYCLE;
    localparam int SH_LOG   = $clog2(2 * PP_PER_CYCLE);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    if (PP_PER_CYCLE != 1 && PP_PER_CYCLE != 2 && PP_PER_CYCLE != 4 &&
        PP_PER_CYCLE != 8 && PP_PER_CYCLE != 16) begin : g_bad_pp_per_cycle
        $error("booth_pp_accum: PP_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    logic [1:0]       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [63:0]      acc_q,     acc_d;
    logic [63:0]      product_q, product_d;
    logic [543:0]     pp_q,      pp_d;
    logic [31:0]      pp16_q,    pp16_d;
    logic [15:0]      ec_q,      ec_d;

    logic [63:0] group_sum;
    logic [63:0] group_weighted;
    logic [5:0]  shamt;
    logic        last_group;

    // pp_q/ec_q shift down each ACCUM cycle, so the current group always sits in
    // the low slots; its absolute weight is restored by one shift of the group sum.
    always_comb begin
        group_sum = '0;
        for (int k = 0; k < PP_PER_CYCLE; k++) begin
            group_sum = group_sum
                      + ({{30{pp_q[34*k+33]}}, pp_q[34*k +: 34]} << (2 * k))
                      + (64'(ec_q[k]) << (2 * k));
        end
    end

    assign shamt          = 6'(cnt_q) << SH_LOG;
    assign group_weighted = group_sum << shamt;
    assign last_group     = (cnt_q == CNT_W'(N_GROUPS - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        product_d = product_q;
        pp_d      = pp_q;
        pp16_d    = pp16_q;
        ec_d      = ec_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    pp_d    = in_pp;
                    pp16_d  = in_pp16;
                    ec_d    = in_ec;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                acc_d = acc_q + group_weighted;
                pp_d  = pp_q >> PP_BITS;
                ec_d  = ec_q >> PP_PER_CYCLE;
                if (last_group) begin
                    state_d = S_FINAL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FINAL: begin
                acc_d     = acc_q + {pp16_q, 32'd0};
                product_d = acc_q + {pp16_q, 32'd0};
                state_d   = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            product_q <= '0;
            pp_q      <= '0;
            pp16_q    <= '0;
            ec_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            pp_q      <= pp_d;
            pp16_q    <= pp16_d;
            ec_q      <= ec_d;
        end
    end

    // Both ports: a transfer happens on a rising edge where valid and ready are both 1;
    // outputs come straight from state, so ready/valid never depend on the other side.
    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign product     = product_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_booth_pp_accum.sv
// Scoreboarded bench for booth_pp_accum: a Booth generator model feeds sets, a plain
// 64-bit multiply predicts each product, and a monitor checks results and latency.
module tb_booth_pp_accum;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [543:0] in_pp;
    logic [31:0]  in_pp16;
    logic [15:0]  in_ec;
    logic         out_ready;

    logic         in_ready_w  [5];
    logic         out_valid_w [5];
    logic [63:0]  product_w   [5];
    logic [1:0]   dbg_state_w [5];

    logic [63:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          accept_cyc = 0;
    bit          rand_ready = 0;

    logic        prev_valid = 0;
    logic        prev_ready = 0;
    logic [63:0] prev_product = '0;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        booth_pp_accum #(.PP_PER_CYCLE(1 << g)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid),
            .in_ready   (in_ready_w[g]),
            .in_pp      (in_pp),
            .in_pp16    (in_pp16),
            .in_ec      (in_ec),
            .out_valid  (out_valid_w[g]),
            .out_ready  (out_ready),
            .product    (product_w[g]),
            .dbg_state_o(dbg_state_w[g])
        );
    end

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Radix-4 Booth generator: digit d_i from b[2i+1:2i-1]; negative digits are
    // stored as (d*a - 1) with the +1 carried in ec[i]. Unsigned b adds a<<32 via PP16.
    function automatic void gen_set(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                                    output logic [543:0] pp, output logic [31:0] pp16,
                                    output logic [15:0] ec);
        longint      av;
        longint      v;
        logic [63:0] t;
        logic [32:0] bx;
        int          d;
        pp = '0;
        ec = '0;
        bx = {b, 1'b0};
        av = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        for (int i = 0; i < 16; i++) begin
            d = -2 * int'(bx[2*i+2]) + int'(bx[2*i+1]) + int'(bx[2*i]);
            v = longint'(d) * av;
            if (d < 0) begin
                v = v - 1;
                ec[i] = 1'b1;
            end
            t = v;
            pp[34*i +: 34] = t[33:0];
        end
        pp16 = (!sgn && b[31]) ? a : 32'd0;
    endfunction

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        longint x;
        longint y;
        if (sgn) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
            return 64'(x * y);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    task automatic scramble_inputs();
        for (int i = 0; i < 17; i++) in_pp[32*i +: 32] = $urandom;
        in_pp16 = $urandom;
        in_ec   = 16'($urandom);
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_raw(input logic [543:0] pp, input logic [31:0] pp16,
                            input logic [15:0] ec, input logic [63:0] exp);
        int n;
        in_pp    = pp;
        in_pp16  = pp16;
        in_ec    = ec;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready_w[0] && n < 200);
        if (!in_ready_w[0]) begin
            fail_now("accept_wait");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        exp_q.push_back(exp);
        in_valid = 1'b0;
        scramble_inputs();
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                        input logic [63:0] exp);
        logic [543:0] pp;
        logic [31:0]  pp16;
        logic [15:0]  ec;
        gen_set(a, b, sgn, pp, pp16, ec);
        send_raw(pp, pp16, ec, exp);
    endtask

    task automatic wait_drained();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) fail_now("drain");
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                check("valid_hold", 64'(out_valid_w[0]), 64'd1);
                check("product_hold", product_w[0], prev_product);
            end
            if (out_valid_w[0]) begin
                if (!prev_valid) begin
                    check("latency", 64'(cyc - accept_cyc), 64'd17);
                    check("in_ready_in_done", 64'(in_ready_w[0]), 64'd0);
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got %h with nothing expected", product_w[0]);
                    end else begin
                        check("product", product_w[0], exp_q.pop_front());
                    end
                end
            end
            prev_valid   = out_valid_w[0];
            prev_ready   = out_ready;
            prev_product = product_w[0];
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        logic [31:0] a;
        logic [31:0] b;
        bit          sgn;
        int          lat [5];
        int          n;
        logic [543:0] pp2;
        logic [31:0]  pp16_2;
        logic [15:0]  ec2;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_pp     = '0;
        in_pp16   = '0;
        in_ec     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready_w[0]), 64'd1);
        check("reset_out_valid", 64'(out_valid_w[0]), 64'd0);
        check("reset_product", product_w[0], 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Correction bits only: sum of 4^i for i = 0..15.
        out_ready = 1'b1;
        send_raw('0, 32'd0, 16'hFFFF, 64'h0000_0000_5555_5555);
        wait_drained();

        // Every PP_PER_CYCLE instance takes the same set on the same edge.
        out_ready = 1'b0;
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        for (int j = 0; j < 5; j++) lat[j] = -1;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            for (int j = 1; j < 5; j++) begin
                if (out_valid_w[j] && lat[j] < 0) lat[j] = cyc - accept_cyc;
            end
        end
        for (int j = 1; j < 5; j++) begin
            check($sformatf("latency_ppc%0d", 1 << j), 64'(lat[j]), 64'(16 / (1 << j) + 1));
            check($sformatf("product_ppc%0d", 1 << j), product_w[j], 64'hFFFF_FFFE_0000_0001);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_drained();

        send(32'd3, 32'hFFFF_FFFE, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
        send(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        wait_drained();

        // Backpressure: a second set waits at the input while the result is held.
        out_ready = 1'b0;
        send(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, ref_mul(32'h1234_5678, 32'h9ABC_DEF0, 1'b0));
        n = 0;
        while (!out_valid_w[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid_w[0]) fail_now("bp_out_valid");
        gen_set(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, pp2, pp16_2, ec2);
        in_pp    = pp2;
        in_pp16  = pp16_2;
        in_ec    = ec2;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", 64'(in_ready_w[0]), 64'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, ref_mul(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1));
        wait_drained();

        // Reset while the counter sits at 7.
        send(32'hCAFE_F00D, 32'h7777_1234, 1'b0, ref_mul(32'hCAFE_F00D, 32'h7777_1234, 1'b0));
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_in_ready", 64'(in_ready_w[0]), 64'd1);
        check("midrst_out_valid", 64'(out_valid_w[0]), 64'd0);
        check("midrst_product", product_w[0], 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        send(32'h0000_ABCD, 32'hFFFF_0003, 1'b1, ref_mul(32'h0000_ABCD, 32'hFFFF_0003, 1'b1));
        wait_drained();

        // Random sets in both modes with a toggling consumer.
        rand_ready = 1'b1;
        for (int t = 0; t < 100; t++) begin
            a   = $urandom;
            b   = $urandom;
            sgn = 1'($urandom_range(0, 1));
            if (t % 10 == 0) a = 32'h8000_0000;
            if (t % 10 == 1) b = 32'hFFFF_FFFF;
            send(a, b, sgn, ref_mul(a, b, sgn));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        wait_drained();

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
